audio_voice_bank: RTL and testbench

- Parametrised successor to the single-voice audio channel. Holds NUM_CHANNELS voices and time-multiplexes them through one memory read port.
- On each lrclk rising edge, fetches one frame per playing voice, scales it by volume, and mixes all voices with saturation into one stereo output pair.
- Sits between the CPU register bus and the I2S serialiser; shares the sample memory with the rest of the audio system.

---
 rtl/audio_voice_pkg.sv | 49 ++++
 rtl/audio_voice_mac.sv | 26 ++
 rtl/audio_voice_bank.sv | 249 ++++++++++++++++++++++++
 tb/tb_audio_voice_bank.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_voice_pkg.sv
// audio_voice_pkg: shared definitions for the multi-voice audio bank.
//   - voiceSelT   : register select codes carried on w_select
//   - voiceStateT : frame sequencer states
//   - saturate()  : clamps a wide signed value to a signed range of 'width' bits
package audio_voice_pkg;

  typedef enum logic [3:0] {
    SelIdle        = 4'd0,
    SelStartAddr   = 4'd1,
    SelSampleCount = 4'd2,
    SelLoopStart   = 4'd3,
    SelLoopEnd     = 4'd4,
    SelPosition    = 4'd5,
    SelVolume      = 4'd6,
    SelLooping     = 4'd7,
    SelPlaying     = 4'd8,
    SelStereo      = 4'd9,
    SelVolumeR     = 4'd12,
    SelClearStatus = 4'd15
  } voiceSelT;

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StReqL,
    StWaitL,
    StReqR,
    StWaitR,
    StAccum,
    StOutput
  } voiceStateT;

  localparam int unsigned SatW = 64;

  function automatic logic signed [SatW-1:0] saturate(input logic signed [SatW-1:0] value,
                                                       input int unsigned            width);
    logic signed [SatW-1:0] maxV;
    logic signed [SatW-1:0] minV;
    maxV = (64'sd1 <<< (width - 1)) - 64'sd1;
    minV = -(64'sd1 <<< (width - 1));
    if (value > maxV) begin
      return maxV;
    end else if (value < minV) begin
      return minV;
    end
    return value;
  endfunction

endpackage

// File: rtl/audio_voice_mac.sv
// audio_voice_mac: combinational scale of one signed sample by an unsigned volume.
//   sample : signed input sample
//   volume : unsigned gain, 2^(VOLUME_W-1) is unity
//   scaled : (sample * volume) >>> (VOLUME_W-1), full precision
module audio_voice_mac #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned VOLUME_W = 8
) (
  input  logic signed [SAMPLE_W-1:0]        sample,
  input  logic        [VOLUME_W-1:0]        volume,
  output logic signed [SAMPLE_W+VOLUME_W:0] scaled
);

  localparam int unsigned MulW = SAMPLE_W + VOLUME_W + 1;

  logic signed [VOLUME_W:0] volumeS;
  logic signed [MulW-1:0]   product;

  always_comb begin
    // Zero-extend so the volume is treated as non-negative in a signed multiply.
    volumeS = {1'b0, volume};
    product = MulW'(sample) * MulW'(volumeS);
    scaled  = product >>> (VOLUME_W - 1);
  end

endmodule

// File: rtl/audio_voice_bank.sv
// audio_voice_bank: NUM_CHANNELS sample voices sharing one memory read port.
// On each rising lrclk edge every playing voice fetches one frame, which is scaled
// by volume and mixed with saturation into o_left/o_right.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   w_channel/w_select/...   : CPU register write (one per cycle)
//   lrclk                    : frame clock, synchronous to clk
//   mem_req_* / mem_rsp_*    : word-addressed sample memory read port
//   o_left/o_right/o_mix_valid : mixed output pair and update pulse
//   o_busy, o_overrun        : sequencer active, sticky frame-overrun flag
// Optional: define AUDIO_VOICE_PAN_EN for an independent right-channel volume per voice.
module audio_voice_bank
  import audio_voice_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned SAMPLE_W     = 16,
  parameter int unsigned VOLUME_W     = 8,
  parameter int unsigned POS_W        = 24,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [$clog2(NUM_CHANNELS)-1:0] w_channel,
  input  logic [3:0]                      w_select,
  input  logic [31:0]                     w_data,
  input  logic                            w_valid,
  input  logic                            lrclk,
  output logic                            mem_req_valid,
  output logic [ADDR_W-1:0]               mem_req_addr,
  input  logic                            mem_req_ready,
  input  logic                            mem_rsp_valid,
  input  logic [SAMPLE_W-1:0]             mem_rsp_data,
  output logic [SAMPLE_W-1:0]             o_left,
  output logic [SAMPLE_W-1:0]             o_right,
  output logic                            o_mix_valid,
  output logic                            o_busy,
  output logic                            o_overrun
);

  localparam int unsigned IdxW = $clog2(NUM_CHANNELS);
  localparam int unsigned MacW = SAMPLE_W + VOLUME_W + 1;
  localparam int unsigned AccW = SAMPLE_W + VOLUME_W + IdxW;

  logic [ADDR_W-1:0]   startAddr   [NUM_CHANNELS];
  logic [POS_W-1:0]    sampleCount [NUM_CHANNELS];
  logic [POS_W-1:0]    loopStart   [NUM_CHANNELS];
  logic [POS_W-1:0]    loopEnd     [NUM_CHANNELS];
  logic [POS_W-1:0]    voicePos    [NUM_CHANNELS];
  logic [VOLUME_W-1:0] volume      [NUM_CHANNELS];
`ifdef AUDIO_VOICE_PAN_EN
  logic [VOLUME_W-1:0] volumeR     [NUM_CHANNELS];
`endif
  logic [NUM_CHANNELS-1:0] looping;
  logic [NUM_CHANNELS-1:0] playing;
  logic [NUM_CHANNELS-1:0] stereo;

  voiceStateT                 state;
  logic [IdxW-1:0]            idx;
  logic                       lrclkQ;
  logic signed [SAMPLE_W-1:0] sampleL;
  logic signed [SAMPLE_W-1:0] sampleR;
  logic signed [AccW-1:0]     accL;
  logic signed [AccW-1:0]     accR;
  logic signed [MacW-1:0]     scaledL;
  logic signed [MacW-1:0]     scaledR;
  logic [VOLUME_W-1:0]        curVolR;
  logic [POS_W-1:0]           curPos;
  logic [POS_W-1:0]           nextPos;
  logic [ADDR_W-1:0]          addrL;
  logic                       frameEdge;
  logic                       lastVoice;

  always_comb begin
    frameEdge = !lrclkQ && lrclk;
    lastVoice = (idx == IdxW'(NUM_CHANNELS - 1));
    curPos    = voicePos[idx];
    nextPos   = curPos + POS_W'(1);
    // Stereo frames are interleaved L,R so each frame occupies two words.
    addrL     = stereo[idx] ? startAddr[idx] + ADDR_W'({curPos, 1'b0})
                            : startAddr[idx] + ADDR_W'(curPos);
`ifdef AUDIO_VOICE_PAN_EN
    curVolR   = volumeR[idx];
`else
    curVolR   = volume[idx];
`endif
  end

  assign o_busy = (state != StIdle);

  audio_voice_mac #(
    .SAMPLE_W(SAMPLE_W),
    .VOLUME_W(VOLUME_W)
  ) u_mac_l (
    .sample(sampleL),
    .volume(volume[idx]),
    .scaled(scaledL)
  );

  audio_voice_mac #(
    .SAMPLE_W(SAMPLE_W),
    .VOLUME_W(VOLUME_W)
  ) u_mac_r (
    .sample(sampleR),
    .volume(curVolR),
    .scaled(scaledR)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        startAddr[i]   <= '0;
        sampleCount[i] <= '0;
        loopStart[i]   <= '0;
        loopEnd[i]     <= '0;
        voicePos[i]    <= '0;
        volume[i]      <= '0;
`ifdef AUDIO_VOICE_PAN_EN
        volumeR[i]     <= '0;
`endif
      end
      looping       <= '0;
      playing       <= '0;
      stereo        <= '0;
      state         <= StIdle;
      idx           <= '0;
      lrclkQ        <= 1'b0;
      sampleL       <= '0;
      sampleR       <= '0;
      accL          <= '0;
      accR          <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      o_left        <= '0;
      o_right       <= '0;
      o_mix_valid   <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      lrclkQ      <= lrclk;
      o_mix_valid <= 1'b0;

      case (state)
        StIdle: begin
          if (frameEdge) begin
            state <= StScan;
            idx   <= '0;
            accL  <= '0;
            accR  <= '0;
          end
        end
        StScan: begin
          if (playing[idx] && (curPos < sampleCount[idx])) begin
            mem_req_valid <= 1'b1;
            mem_req_addr  <= addrL;
            state         <= StReqL;
          end else begin
            // Covers both idle voices and voices that ran past their end.
            playing[idx] <= 1'b0;
            if (lastVoice) begin
              state <= StOutput;
            end else begin
              idx <= idx + IdxW'(1);
            end
          end
        end
        StReqL: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= StWaitL;
          end
        end
        StWaitL: begin
          if (mem_rsp_valid) begin
            sampleL <= mem_rsp_data;
            if (stereo[idx]) begin
              mem_req_valid <= 1'b1;
              mem_req_addr  <= addrL + ADDR_W'(1);
              state         <= StReqR;
            end else begin
              sampleR <= mem_rsp_data;
              state   <= StAccum;
            end
          end
        end
        StReqR: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= StWaitR;
          end
        end
        StWaitR: begin
          if (mem_rsp_valid) begin
            sampleR <= mem_rsp_data;
            state   <= StAccum;
          end
        end
        StAccum: begin
          accL <= accL + AccW'(scaledL);
          accR <= accR + AccW'(scaledR);
          if (looping[idx] && (nextPos >= loopEnd[idx])) begin
            voicePos[idx] <= loopStart[idx];
          end else begin
            voicePos[idx] <= nextPos;
            if (nextPos >= sampleCount[idx]) begin
              playing[idx] <= 1'b0;
            end
          end
          if (lastVoice) begin
            state <= StOutput;
          end else begin
            idx   <= idx + IdxW'(1);
            state <= StScan;
          end
        end
        StOutput: begin
          o_left      <= SAMPLE_W'(saturate(SatW'(accL), SAMPLE_W));
          o_right     <= SAMPLE_W'(saturate(SatW'(accR), SAMPLE_W));
          o_mix_valid <= 1'b1;
          state       <= StIdle;
        end
        default: state <= StIdle;
      endcase

      // Placed after the sequencer so CPU writes win on the same voice and cycle.
      if (w_valid) begin
        case (w_select)
          SelStartAddr:   startAddr[w_channel]   <= ADDR_W'(w_data);
          SelSampleCount: sampleCount[w_channel] <= POS_W'(w_data);
          SelLoopStart:   loopStart[w_channel]   <= POS_W'(w_data);
          SelLoopEnd:     loopEnd[w_channel]     <= POS_W'(w_data);
          SelPosition:    voicePos[w_channel]    <= POS_W'(w_data);
          SelVolume:      volume[w_channel]      <= VOLUME_W'(w_data);
          SelLooping:     looping[w_channel]     <= w_data[0];
          SelPlaying:     playing[w_channel]     <= w_data[0];
          SelStereo:      stereo[w_channel]      <= w_data[0];
`ifdef AUDIO_VOICE_PAN_EN
          SelVolumeR:     volumeR[w_channel]     <= VOLUME_W'(w_data);
`endif
          SelClearStatus: o_overrun              <= 1'b0;
          default: ;
        endcase
      end

      if (frameEdge && (state != StIdle)) begin
        o_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_audio_voice_bank.sv
// Directed self-checking bench for audio_voice_bank (default build, no panning).
module tb_audio_voice_bank;
  import audio_voice_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  w_channel = '0;
  logic [3:0]  w_select = '0;
  logic [31:0] w_data = '0;
  logic        w_valid = 1'b0;
  logic        lrclk = 1'b0;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b1;
  logic        mem_rsp_valid = 1'b0;
  logic [15:0] mem_rsp_data = '0;
  logic [15:0] o_left;
  logic [15:0] o_right;
  logic        o_mix_valid;
  logic        o_busy;
  logic        o_overrun;

  always #5 clk = ~clk;

  audio_voice_bank #(
    .NUM_CHANNELS(4),
    .SAMPLE_W(16),
    .VOLUME_W(8),
    .POS_W(24),
    .ADDR_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .w_channel(w_channel),
    .w_select(w_select),
    .w_data(w_data),
    .w_valid(w_valid),
    .lrclk(lrclk),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .o_left(o_left),
    .o_right(o_right),
    .o_mix_valid(o_mix_valid),
    .o_busy(o_busy),
    .o_overrun(o_overrun)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          reqCount = 0;
  int          mixCount = 0;
  logic [31:0] reqLog [64];
  logic [15:0] memArr [logic [31:0]];
  bit          autoRsp = 1'b1;
  bit          forceRsp = 1'b0;

  // Memory model: answers each accepted request one cycle later.
  always @(posedge clk) begin
    bit          accepted;
    logic [31:0] addr;
    accepted = mem_req_valid && mem_req_ready && !rst;
    addr     = mem_req_addr;
    #1;
    mem_rsp_valid = 1'b0;
    if (accepted) begin
      reqLog[reqCount % 64] = addr;
      reqCount++;
      if (autoRsp) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = memArr.exists(addr) ? memArr[addr] : 16'h0000;
      end
    end
    if (forceRsp) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 16'h7777;
      forceRsp      = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (o_mix_valid) mixCount++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic writeReg(input int ch, input logic [3:0] sel, input logic [31:0] d);
    w_channel = 2'(ch);
    w_select  = sel;
    w_data    = d;
    w_valid   = 1'b1;
    @(negedge clk);
    w_valid   = 1'b0;
  endtask

  task automatic setVoice(input int ch, input logic [31:0] start, input logic [31:0] count,
                          input logic [31:0] pos, input logic [31:0] vol);
    writeReg(ch, SelStartAddr, start);
    writeReg(ch, SelSampleCount, count);
    writeReg(ch, SelPosition, pos);
    writeReg(ch, SelVolume, vol);
    writeReg(ch, SelPlaying, 32'd1);
  endtask

  task automatic waitMix(input string tag, input int base);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (mixCount != base) seen = 1'b1;
    end
    check({tag, " done"}, 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
    check({tag, " pulses"}, 32'(mixCount - base), 32'd1);
  endtask

  task automatic frame(input string tag);
    int base;
    base  = mixCount;
    lrclk = 1'b1;
    @(negedge clk);
    lrclk = 1'b0;
    waitMix(tag, base);
  endtask

  initial begin
    int base;
    int unstable;
    bit seen;

    repeat (3) @(negedge clk);
    check("rst left", 32'(o_left), 32'h0);
    check("rst right", 32'(o_right), 32'h0);
    check("rst req", 32'(mem_req_valid), 32'h0);
    check("rst busy", 32'(o_busy), 32'h0);
    check("rst overrun", 32'(o_overrun), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single mono voice at unity gain.
    memArr[32'h100] = 16'h1000;
    setVoice(0, 32'h100, 32'd100, 32'd0, 32'd128);
    base = reqCount;
    frame("mono");
    check("mono reqs", 32'(reqCount - base), 32'd1);
    check("mono addr", reqLog[(reqCount - 1) % 64], 32'h100);
    check("mono left", 32'(o_left), 32'h1000);
    check("mono right", 32'(o_right), 32'h1000);
    check("mono pos", 32'(dut.voicePos[0]), 32'd1);

    // Two voices saturating high then low.
    memArr[32'h101] = 16'h6000;
    memArr[32'h300] = 16'h6000;
    setVoice(1, 32'h300, 32'd100, 32'd0, 32'd128);
    frame("sat hi");
    check("sat hi left", 32'(o_left), 32'h7FFF);
    check("sat hi right", 32'(o_right), 32'h7FFF);
    memArr[32'h102] = 16'hA000;
    memArr[32'h301] = 16'hA000;
    frame("sat lo");
    check("sat lo left", 32'(o_left), 32'h8000);
    check("sat lo right", 32'(o_right), 32'h8000);

    // Half volume on one voice.
    writeReg(1, SelPlaying, 32'd0);
    writeReg(0, SelVolume, 32'd64);
    memArr[32'h103] = 16'h6000;
    frame("half");
    check("half left", 32'(o_left), 32'h3000);
    check("half right", 32'(o_right), 32'h3000);

    // Stereo voice: two requests, interleaved addresses.
    writeReg(0, SelPlaying, 32'd0);
    memArr[32'h20A] = 16'h0111;
    memArr[32'h20B] = 16'h0222;
    writeReg(2, SelStereo, 32'd1);
    setVoice(2, 32'h200, 32'd100, 32'd5, 32'd128);
    base = reqCount;
    frame("stereo");
    check("stereo reqs", 32'(reqCount - base), 32'd2);
    check("stereo addr l", reqLog[base % 64], 32'h20A);
    check("stereo addr r", reqLog[(base + 1) % 64], 32'h20B);
    check("stereo left", 32'(o_left), 32'h0111);
    check("stereo right", 32'(o_right), 32'h0222);

    // Looping wraps to loop start.
    writeReg(2, SelPlaying, 32'd0);
    memArr[32'h403] = 16'h0500;
    writeReg(3, SelLoopStart, 32'd2);
    writeReg(3, SelLoopEnd, 32'd4);
    writeReg(3, SelLooping, 32'd1);
    setVoice(3, 32'h400, 32'd100, 32'd3, 32'd128);
    frame("loop");
    check("loop pos", 32'(dut.voicePos[3]), 32'd2);
    check("loop playing", 32'(dut.playing[3]), 32'd1);
    check("loop left", 32'(o_left), 32'h0500);

    // Non-looping voice stops at its end, then stays silent.
    writeReg(3, SelLooping, 32'd0);
    writeReg(3, SelSampleCount, 32'd4);
    writeReg(3, SelPosition, 32'd3);
    frame("end");
    check("end playing", 32'(dut.playing[3]), 32'd0);
    check("end pos", 32'(dut.voicePos[3]), 32'd4);
    check("end left", 32'(o_left), 32'h0500);
    base = reqCount;
    frame("silent");
    check("silent reqs", 32'(reqCount - base), 32'd0);
    check("silent left", 32'(o_left), 32'h0);
    check("silent right", 32'(o_right), 32'h0);

    // Memory stall with an overrun edge in the middle.
    memArr[32'h400] = 16'h0123;
    writeReg(3, SelPosition, 32'd0);
    writeReg(3, SelSampleCount, 32'd100);
    writeReg(3, SelPlaying, 32'd1);
    mem_req_ready = 1'b0;
    base  = mixCount;
    lrclk = 1'b1;
    @(negedge clk);
    lrclk = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (mem_req_valid) seen = 1'b1;
    end
    check("stall req", 32'(seen), 32'd1);
    check("stall addr", mem_req_addr, 32'h400);
    unstable = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 50) lrclk = 1'b1;
      if (i == 52) lrclk = 1'b0;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h400) unstable++;
    end
    check("stall stable", 32'(unstable), 32'd0);
    check("stall overrun", 32'(o_overrun), 32'd1);
    check("stall busy", 32'(o_busy), 32'd1);
    mem_req_ready = 1'b1;
    waitMix("stall", base);
    check("stall left", 32'(o_left), 32'h0123);
    writeReg(0, SelClearStatus, 32'd0);
    check("clear overrun", 32'(o_overrun), 32'd0);

    // Reset while waiting for a response; the late response must be dropped.
    autoRsp = 1'b0;
    lrclk = 1'b1;
    @(negedge clk);
    lrclk = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (mem_req_valid) seen = 1'b1;
    end
    check("rstw req", 32'(seen), 32'd1);
    check("rstw addr", mem_req_addr, 32'h401);
    @(negedge clk);
    check("rstw in wait", 32'({o_busy, mem_req_valid}), 32'h2);
    rst = 1'b1;
    @(negedge clk);
    check("rstw req off", 32'(mem_req_valid), 32'd0);
    check("rstw left", 32'(o_left), 32'h0);
    check("rstw right", 32'(o_right), 32'h0);
    check("rstw busy", 32'(o_busy), 32'd0);
    rst = 1'b0;
    base = mixCount;
    forceRsp = 1'b1;
    repeat (4) @(negedge clk);
    check("late rsp busy", 32'(o_busy), 32'd0);
    check("late rsp mix", 32'(mixCount - base), 32'd0);
    autoRsp = 1'b1;
    memArr[32'h500] = 16'h0042;
    setVoice(0, 32'h500, 32'd10, 32'd0, 32'd128);
    base = reqCount;
    frame("post rst");
    check("post rst reqs", 32'(reqCount - base), 32'd1);
    check("post rst addr", reqLog[(reqCount - 1) % 64], 32'h500);
    check("post rst left", 32'(o_left), 32'h0042);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
